// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, 3-bit colours, choice codes
// and the box_plotter state encoding.
package game_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef enum logic [2:0] {
    CH_NONE    = 3'b000,
    CH_CAT     = 3'b001,
    CH_DOG     = 3'b010,
    CH_CHICKEN = 3'b100
  } choice_e;

  typedef enum logic [1:0] {
    BP_IDLE = 2'd0,
    BP_DRAW = 2'd1,
    BP_DONE = 2'd2
  } bp_state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster-order cx/cy offset counters; exposes the next position,
// a last-pixel flag and the border flag of the next position.
module raster_counter #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [XW-1:0] w_i,
  input  logic [YW-1:0] h_i,
  output logic [XW-1:0] nx_o,
  output logic [YW-1:0] ny_o,
  output logic          last_o,
  output logic          edge_o
);

  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [XW-1:0] wm1;
  logic [YW-1:0] hm1;
  logic          xend;

  assign wm1  = w_i - XW'(1);
  assign hm1  = h_i - YW'(1);
  assign xend = (cx_q == wm1);

  always_comb begin
    nx_o = cx_q + XW'(1);
    ny_o = cy_q;
    if (xend) begin
      nx_o = '0;
      ny_o = cy_q + YW'(1);
    end
  end

  assign last_o = xend && (cy_q == hm1);

  // Border test is on the position about to be presented.
  assign edge_o = (nx_o == '0) || (nx_o == wm1) ||
                  (ny_o == '0) || (ny_o == hm1);

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (load_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (adv_i) begin
      cx_d = nx_o;
      cy_d = ny_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/box_plotter.sv
// Filled-rectangle / clear-screen pixel writer for the VGA adapter.
// Optional BOX_PLOTTER_OUTLINE_EN adds an outline-only draw mode.
module box_plotter #(
  parameter int SCREEN_W = game_pkg::SCREEN_W,
  parameter int SCREEN_H = game_pkg::SCREEN_H,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic          clear,
`ifdef BOX_PLOTTER_OUTLINE_EN
  input  logic          outline,
`endif
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  input  logic [CW-1:0] colour_in,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot
);

  import game_pkg::*;

  localparam logic [XW:0] XLIM = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] YLIM = (YW+1)'(SCREEN_H);

  bp_state_e     state_q;
  logic [XW-1:0] x0_q, w_q, x_q;
  logic [YW-1:0] y0_q, h_q, y_q;
  logic [CW-1:0] col_q;
  logic          busy_q, done_q, plot_q;

  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          last, bord;
  logic          go, empty_in, load, adv;
  logic [XW-1:0] ox0, ow;
  logic [YW-1:0] oy0, oh;
  logic [XW:0]   xs0, xs;
  logic [YW:0]   ys0, ys;
  logic          in0, pix_on;

  assign go       = (state_q == BP_IDLE) && start;
  assign empty_in = !clear && ((w == '0) || (h == '0));
  assign load     = go && !empty_in;
  assign adv      = (state_q == BP_DRAW) && !last;

  assign ox0 = clear ? '0 : x0;
  assign oy0 = clear ? '0 : y0;
  assign ow  = clear ? XW'(SCREEN_W) : w;
  assign oh  = clear ? YW'(SCREEN_H) : h;

  // Pixel 0 goes out on the start edge, so it uses the live inputs.
  assign xs0 = {1'b0, ox0};
  assign ys0 = {1'b0, oy0};
  assign in0 = (xs0 < XLIM) && (ys0 < YLIM);

  assign xs = {1'b0, x0_q} + {1'b0, nx};
  assign ys = {1'b0, y0_q} + {1'b0, ny};

`ifdef BOX_PLOTTER_OUTLINE_EN
  logic outl_q;
  assign pix_on = (xs < XLIM) && (ys < YLIM) &&
                  (!outl_q || bord);
`else
  logic unused_bord;
  assign unused_bord = bord;
  assign pix_on = (xs < XLIM) && (ys < YLIM);
`endif

  raster_counter #(
    .XW(XW),
    .YW(YW)
  ) u_cnt (
    .clk   (clock),
    .rst_n (resetn),
    .load_i(load),
    .adv_i (adv),
    .w_i   (w_q),
    .h_i   (h_q),
    .nx_o  (nx),
    .ny_o  (ny),
    .last_o(last),
    .edge_o(bord)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= BP_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
`ifdef BOX_PLOTTER_OUTLINE_EN
      outl_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        BP_IDLE: begin
          done_q <= 1'b0;
          plot_q <= 1'b0;
          if (go && empty_in) begin
            state_q <= BP_DONE;
            done_q  <= 1'b1;
          end else if (go) begin
            state_q <= BP_DRAW;
            x0_q    <= ox0;
            y0_q    <= oy0;
            w_q     <= ow;
            h_q     <= oh;
            col_q   <= colour_in;
            x_q     <= xs0[XW-1:0];
            y_q     <= ys0[YW-1:0];
            busy_q  <= 1'b1;
            plot_q  <= in0;
`ifdef BOX_PLOTTER_OUTLINE_EN
            outl_q  <= outline && !clear;
`endif
          end
        end
        BP_DRAW: begin
          if (last) begin
            state_q <= BP_DONE;
            busy_q  <= 1'b0;
            plot_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            x_q    <= xs[XW-1:0];
            y_q    <= ys[YW-1:0];
            plot_q <= pix_on;
          end
        end
        BP_DONE: begin
          state_q <= BP_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= BP_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          plot_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = col_q;
  assign plot   = plot_q;

endmodule

// File: tb/tb_box_plotter.sv
// Directed self-checking bench for box_plotter.
// Build with BOX_PLOTTER_OUTLINE_EN to also cover outline mode.
module tb_box_plotter;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [7:0] w = '0;
  logic [6:0] h = '0;
  logic [2:0] colour_in = '0;
  logic       busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
`ifdef BOX_PLOTTER_OUTLINE_EN
  logic       outline = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  bit seen [160][120];

  always #5 clock = ~clock;

  box_plotter dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .clear    (clear),
`ifdef BOX_PLOTTER_OUTLINE_EN
    .outline  (outline),
`endif
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .colour_in(colour_in),
    .busy     (busy),
    .done     (done),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Pulse start for one edge, then scramble the inputs.
  task automatic go(input logic [7:0] gx, input logic [6:0] gy,
                    input logic [7:0] gw, input logic [6:0] gh,
                    input logic [2:0] gc, input logic gclr);
    x0 = gx; y0 = gy; w = gw; h = gh;
    colour_in = gc; clear = gclr; start = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    x0 = 8'd77; y0 = 7'd99; w = 8'd2; h = 7'd2;
    colour_in = 3'b011;
  endtask

  initial begin
    int pcnt, dcnt, berr, bcnt;
    logic [7:0] ex;
    logic [6:0] ey;

    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_plot", plot, 0);
    resetn = 1'b1;
    step();

    // 3x2 box at (10,5)
    go(8'd10, 7'd5, 8'd3, 7'd2, 3'b100, 1'b0);
    for (int n = 0; n < 6; n++) begin
      ex = 8'(10 + n % 3);
      ey = 7'(5 + n / 3);
      chk("box_x", x, ex);
      chk("box_y", y, ey);
      chk("box_plot", plot, 1);
      chk("box_busy", busy, 1);
      chk("box_colour", colour, 3'b100);
      step();
    end
    chk("box_done", done, 1);
    chk("box_busy_end", busy, 0);
    chk("box_plot_end", plot, 0);
    step();
    chk("box_done_drop", done, 0);

    // Right-edge clipping
    go(8'd158, 7'd0, 8'd4, 7'd1, 3'b010, 1'b0);
    for (int n = 0; n < 4; n++) begin
      chk("clip_x", x, 158 + n);
      chk("clip_plot", plot, (n < 2) ? 1 : 0);
      chk("clip_busy", busy, 1);
      step();
    end
    chk("clip_done", done, 1);
    chk("clip_busy_end", busy, 0);
    step();

    // Empty rectangle
    go(8'd50, 7'd50, 8'd0, 7'd5, 3'b111, 1'b0);
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    chk("empty_plot", plot, 0);
    step();
    chk("empty_done_drop", done, 0);
    chk("empty_plot2", plot, 0);

    // 4x4 box with a start pulsed mid-draw
    go(8'd20, 7'd20, 8'd4, 7'd4, 3'b001, 1'b0);
    pcnt = 0;
    for (int n = 0; n < 16; n++) begin
      if (plot) pcnt++;
      chk("ign_x", x, 20 + n % 4);
      chk("ign_y", y, 20 + n / 4);
      start = (n == 5);
      clear = (n == 5);
      step();
    end
    start = 1'b0;
    clear = 1'b0;
    chk("ign_plots", pcnt, 16);
    chk("ign_done", done, 1);
    step();
    chk("ign_idle_busy", busy, 0);
    step();
    chk("ign_no_restart", busy, 0);

    // Clear screen with black; origin/size inputs must be ignored
    go(8'd99, 7'd99, 8'd1, 7'd1, 3'b000, 1'b1);
    chk("clr_first_x", x, 0);
    chk("clr_first_y", y, 0);
    pcnt = 0; dcnt = 0; berr = 0;
    for (int n = 0; n < 19200; n++) begin
      if (!busy) berr++;
      if (plot) begin
        pcnt++;
        if (x < 160 && y < 120 && !seen[x][y]) begin
          seen[x][y] = 1'b1;
          dcnt++;
        end
      end
      if (n == 19199) begin
        chk("clr_last_x", x, 159);
        chk("clr_last_y", y, 119);
        chk("clr_last_plot", plot, 1);
      end
      step();
    end
    chk("clr_plots", pcnt, 19200);
    chk("clr_distinct", dcnt, 19200);
    chk("clr_busy_gaps", berr, 0);
    chk("clr_colour", colour, 3'b000);
    chk("clr_done", done, 1);
    step();

    // Asynchronous reset during a 10x10 draw
    go(8'd30, 7'd30, 8'd10, 7'd10, 3'b010, 1'b0);
    repeat (36) step();
    chk("rr_pix36_x", x, 36);
    chk("rr_pix36_y", y, 33);
    chk("rr_pix36_plot", plot, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rr_plot", plot, 0);
    chk("rr_busy", busy, 0);
    chk("rr_x", x, 0);
    chk("rr_y", y, 0);
    chk("rr_colour", colour, 0);
    chk("rr_done", done, 0);
    @(negedge clock);
    resetn = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 5; n++) begin
      if (done || busy) dcnt++;
      step();
    end
    chk("rr_no_done", dcnt, 0);
    go(8'd0, 7'd0, 8'd1, 7'd1, 3'b111, 1'b0);
    chk("one_plot", plot, 1);
    chk("one_x", x, 0);
    chk("one_y", y, 0);
    chk("one_busy", busy, 1);
    chk("one_colour", colour, 3'b111);
    step();
    chk("one_done", done, 1);
    chk("one_plot_end", plot, 0);
    step();

`ifdef BOX_PLOTTER_OUTLINE_EN
    // 4x3 outline: interior (1,1),(2,1) suppressed
    outline = 1'b1;
    x0 = 8'd0;
    go(8'd0, 7'd0, 8'd4, 7'd3, 3'b101, 1'b0);
    outline = 1'b0;
    pcnt = 0; bcnt = 0;
    for (int n = 0; n < 12; n++) begin
      if (plot) pcnt++;
      if (busy) bcnt++;
      if (n == 5) chk("ol_int11", plot, 0);
      if (n == 6) chk("ol_int21", plot, 0);
      step();
    end
    chk("ol_plots", pcnt, 10);
    chk("ol_busy", bcnt, 12);
    chk("ol_done", done, 1);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
